spram_16k16: RTL and testbench
==============================

Name: spram_16k16

Overview:
- Single-port synchronous 16K x 16 RAM with a 1-cycle registered read and per-nibble write masking.
- One instance of this block is one 16 KW bank; the VRAM wrapper instantiates four of them, decodes address[15:14] into chip_select, and muxes data_out by the registered bank number.
- Also provides standby, sleep and power-off low-power controls.

Parameters:
- ADDR_W, 14, word address width; depth = 2**ADDR_W.
- DATA_W, 16, word width; must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- address  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- mask_wren  input  DATA_W/4  nibble write enables; bit n enables data bits [4n+3:4n].
- wren  input  1  1 = write cycle, 0 = read cycle.
- chip_select  input  1  access enable.
- standby  input  1  1 = standby: no access, contents kept.
- sleep  input  1  1 = sleep: output forced to 0, contents kept.
- poweroff  input  1  active-low; 0 = powered off, contents lost.
- data_out  output  DATA_W  registered read data.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low clears data_out to 0 immediately, with no clock edge needed.
  - Memory array is not cleared.
  - No writes occur while rst_n is low.
- Mode priority, highest first: poweroff=0, then sleep=1, then standby=1, then chip_select.
- Access on a clk edge requires all of: rst_n=1, poweroff=1, sleep=0, standby=0, chip_select=1.
  - Write (wren=1): for each mask bit set, memory[address] nibble <= data_in nibble; unmasked nibbles unchanged.
  - Read timing: data_out <= memory[address] on every access, including write cycles.
  - Read-before-write: on a write cycle data_out shows the word's contents before the write.
  - Read latency is 1 cycle: address applied before edge N gives data on data_out after edge N.
- chip_select=0: no read, no write; data_out holds its last value.
- standby=1: no access; data_out holds; contents retained.
- sleep=1:
  - data_out reads 0 (combinational force) while sleep is high.
  - Output register is cleared to 0 on the next clk edge; contents retained.
  - After sleep falls, data_out stays 0 until the next access.
- poweroff=0:
  - data_out forced to 0 and output register cleared.
  - Every memory word reads 0 after power is restored (contents-lost behaviour).
  - No accesses while powered off.
  - The first access is allowed on the first clk edge with poweroff=1.
- Mask handling:
  - mask_wren=0 with wren=1 is a plain read; no word changes.
  - mask_wren=4'hF writes the full word.
- Addressing: the full 2**ADDR_W range is valid; no wrap or aliasing inside the block.
- Back-to-back accesses every cycle are supported; no stall or handshake.
- Initial memory contents are undefined except after a power-off cycle (all 0).

Optional Feature:
- Macro: SPRAM_LOWPOWER_EN.
- Defined: standby, sleep and poweroff behave as described in Behaviour.
- Undefined: standby, sleep and poweroff are ignored, as if standby=0, sleep=0, poweroff=1.
  - Only chip_select, wren and rst_n gate access.
  - Ports remain present for interface compatibility.

Test Plan:
- Reset: rst_n=0 mid-cycle after data_out=16'h1234 -> data_out=0 with no clock edge; write of 16'hBEEF attempted while rst_n=0 -> address later reads its old value.
- Write then read: write 16'hA5C3 to 14'h0100 with mask_wren=4'hF -> read of 14'h0100 returns 16'hA5C3 one edge later; the write cycle itself returns the prior word on data_out.
- Nibble mask: word holds 16'h1234; write 16'hABCD with mask_wren=4'b0101 -> reads 16'h1B3D.
- chip_select/standby: chip_select=0 or standby=1 with wren=1, data 16'hFFFF -> word unchanged, data_out holds its previous value.
- Sleep: sleep=1 -> data_out=0; sleep=0 then read -> original contents intact. Poweroff: poweroff=0 for 2 cycles, then poweroff=1 and read 14'h0100 -> 16'h0000.
- Macro undefined: sleep=1 and poweroff=0 during a write of 16'h5A5A -> write and read complete normally.

Source files
------------

// File: rtl/spram_16k16.sv
// spram_16k16: single-port synchronous 16K x 16 RAM bank.
//
// One word per clock, 1-cycle registered read, per-nibble write masking and
// read-before-write: on a write cycle data_out shows the word's old contents.
//
// Low-power controls (standby, sleep, poweroff) are active only when the
// macro SPRAM_LOWPOWER_EN is defined. Without it the three pins stay on the
// port list for interface compatibility but are ignored, and only
// chip_select, wren and rst_n gate an access.
//
// Power-off loses the array contents. A RAM cannot be cleared in one cycle,
// so a per-word valid bit records whether the word has been written since
// the last power-off. An invalid word reads as zero, and its unmasked
// nibbles are written as zero, so the array behaves as if it had been
// zero-filled.

`timescale 1ns/1ps

module spram_16k16 #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/4-1:0]   mask_wren,
    input  logic                  wren,
    input  logic                  chip_select,
    input  logic                  standby,
    input  logic                  sleep,
    input  logic                  poweroff,
    output logic [DATA_W-1:0]     data_out
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NIBS  = DATA_W / 4;

    // Effective low-power mode, after the build option is applied
    logic power_on;
    logic sleep_on;
    logic standby_on;

`ifdef SPRAM_LOWPOWER_EN
    assign power_on   = poweroff;
    assign sleep_on   = sleep;
    assign standby_on = standby;
`else
    assign power_on   = 1'b1;
    assign sleep_on   = 1'b0;
    assign standby_on = 1'b0;

    // Pins kept for interface compatibility only
    logic unused_lowpower;
    assign unused_lowpower = &{1'b0, standby, sleep, poweroff};
`endif

    // Access qualification, in mode priority order
    logic force_zero;
    logic access;
    logic write_en;

    assign force_zero = !power_on || sleep_on;
    assign access     = rst_n && power_on && !sleep_on && !standby_on && chip_select;
    assign write_en   = access && wren && (|mask_wren);

    // Storage
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] stored_word;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] data_q;

`ifdef SPRAM_LOWPOWER_EN
    logic [DEPTH-1:0]  word_valid;

    // A word that has not been written since power-off reads as zero
    assign stored_word = word_valid[address] ? mem[address] : '0;

    // Valid bits drop while powered off and are set by each write
    always_ff @(posedge clk) begin
        if (!power_on) begin
            word_valid <= '0;
        end else if (write_en) begin
            word_valid[address] <= 1'b1;
        end
    end
`else
    assign stored_word = mem[address];
`endif

    // Overlay the enabled nibbles of data_in on the current word
    always_comb begin
        merged_word = stored_word;
        for (int n = 0; n < NIBS; n++) begin
            if (mask_wren[n]) begin
                merged_word[4*n +: 4] = data_in[4*n +: 4];
            end
        end
    end

    // Array write; the array itself is never reset
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[address] <= merged_word;
        end
    end

    // Output register: old word on every access, cleared by sleep/power-off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (force_zero) begin
            data_q <= '0;
        end else if (access) begin
            data_q <= stored_word;
        end
    end

    // Sleep and power-off blank the output at once, without waiting for a clock
    assign data_out = force_zero ? '0 : data_q;

endmodule

// File: tb/tb_spram_16k16.sv
// tb_spram_16k16: scoreboard bench for spram_16k16.
// Stimulus pushes expected data_out values with the cycle they are due in.
// A monitor process pops and compares them on the falling clock edge.

`timescale 1ns/1ps

module tb_spram_16k16;

    logic        clk;
    logic        rst_n;
    logic [13:0] address;
    logic [15:0] data_in;
    logic [3:0]  mask_wren;
    logic        wren;
    logic        chip_select;
    logic        standby;
    logic        sleep;
    logic        poweroff;
    logic [15:0] data_out;

    // Mode vectors: {rst_n, standby, sleep, poweroff}
    localparam logic [3:0] MD_RUN  = 4'b1001;
    localparam logic [3:0] MD_RST  = 4'b0001;
    localparam logic [3:0] MD_SB   = 4'b1101;
    localparam logic [3:0] MD_SL   = 4'b1011;
    localparam logic [3:0] MD_PO   = 4'b1000;
    localparam logic [3:0] MD_SLPO = 4'b1010;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          due_q[$];
    string       name_q[$];

    spram_16k16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .data_in     (data_in),
        .mask_wren   (mask_wren),
        .wren        (wren),
        .chip_select (chip_select),
        .standby     (standby),
        .sleep       (sleep),
        .poweroff    (poweroff),
        .data_out    (data_out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time scoreboard entries
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expectOutput(input logic [15:0] v, input int due, input string nm);
        exp_q.push_back(v);
        due_q.push_back(due);
        name_q.push_back(nm);
    endtask

    task automatic checkOutput(input logic [15:0] v, input string nm);
        checks++;
        if (data_out !== v) begin
            errors++;
            $display("[TB] FAIL %s: data_out=%h expected=%h (cycle %0d)", nm, data_out, v, cyc);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge; optionally expect a
    // value before the next edge (now) and/or after the next edge (next)
    task automatic applyStimulus(input logic [13:0] a, input logic [15:0] d,
                                 input logic [3:0] m, input logic we, input logic cs,
                                 input logic [3:0] md,
                                 input logic chk_now, input logic [15:0] now_v,
                                 input logic chk_next, input logic [15:0] next_v,
                                 input string nm);
        @(posedge clk);
        #1;
        address     = a;
        data_in     = d;
        mask_wren   = m;
        wren        = we;
        chip_select = cs;
        {rst_n, standby, sleep, poweroff} = md;
        if (chk_now)  expectOutput(now_v, cyc, {nm, "_now"});
        if (chk_next) expectOutput(next_v, cyc + 1, nm);
    endtask

    task automatic doWrite(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m,
                           input logic chk, input logic [15:0] v, input string nm);
        applyStimulus(a, d, m, 1'b1, 1'b1, MD_RUN, 1'b0, 16'h0, chk, v, nm);
    endtask

    task automatic doRead(input logic [13:0] a, input logic [15:0] v, input string nm);
        applyStimulus(a, 16'h0, 4'h0, 1'b0, 1'b1, MD_RUN, 1'b0, 16'h0, 1'b1, v, nm);
    endtask

    task automatic doIdle();
        applyStimulus(14'h0, 16'h0, 4'h0, 1'b0, 1'b0, MD_RUN, 1'b0, 16'h0, 1'b0, 16'h0, "idle");
    endtask

    task automatic printSummary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    // Monitor: compare every entry that has come due
    initial begin
        forever begin
            @(negedge clk);
            while (due_q.size() > 0 && due_q[0] <= cyc) begin
                checkOutput(exp_q[0], name_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
                void'(name_q.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        printSummary();
        $fatal(1, "[TB] timeout");
    end

    // Directed stimulus
    initial begin
        rst_n       = 1'b1;
        address     = '0;
        data_in     = '0;
        mask_wren   = '0;
        wren        = 1'b0;
        chip_select = 1'b0;
        standby     = 1'b0;
        sleep       = 1'b0;
        poweroff    = 1'b1;
        #1;
        rst_n = 1'b0;
        expectOutput(16'h0000, cyc, "reset_init");

        doIdle();

        // Full write, read-before-write, registered read
        doWrite(14'h0100, 16'h1111, 4'hF, 1'b0, 16'h0, "wr_init");
        doWrite(14'h0100, 16'hA5C3, 4'hF, 1'b1, 16'h1111, "wr_prior");
        doRead (14'h0100, 16'hA5C3, "rd_a5c3");

        // Nibble mask 0101 over 1234 with ABCD
        doWrite(14'h0200, 16'h1234, 4'hF, 1'b0, 16'h0, "wr_1234");
        doWrite(14'h0200, 16'hABCD, 4'b0101, 1'b1, 16'h1234, "mask_prior");
        doRead (14'h0200, 16'h1B3D, "mask_rd");

        // Zero mask is a plain read
        applyStimulus(14'h0100, 16'hFFFF, 4'h0, 1'b1, 1'b1, MD_RUN, 1'b0, 16'h0, 1'b1, 16'hA5C3, "mask0_rd");
        doRead (14'h0100, 16'hA5C3, "mask0_kept");

        // chip_select low blocks the write and holds data_out
        applyStimulus(14'h0200, 16'hFFFF, 4'hF, 1'b1, 1'b0, MD_RUN, 1'b0, 16'h0, 1'b1, 16'hA5C3, "cs0_hold");
        doRead (14'h0200, 16'h1B3D, "cs0_kept");

        // Address range ends, no aliasing
        doWrite(14'h3FFF, 16'h0F0F, 4'hF, 1'b0, 16'h0, "wr_top");
        doWrite(14'h0000, 16'hF0F0, 4'hF, 1'b0, 16'h0, "wr_bot");
        doRead (14'h3FFF, 16'h0F0F, "top_addr");
        doRead (14'h0000, 16'hF0F0, "bot_addr");

        // Asynchronous reset mid-cycle, write blocked while in reset
        doWrite(14'h0300, 16'h1234, 4'hF, 1'b0, 16'h0, "wr_0300");
        doRead (14'h0300, 16'h1234, "pre_reset");
        doIdle();
        applyStimulus(14'h0300, 16'hBEEF, 4'hF, 1'b1, 1'b1, MD_RST, 1'b1, 16'h0000, 1'b1, 16'h0000, "reset_async");
        doRead (14'h0300, 16'h1234, "reset_nowrite");

`ifdef SPRAM_LOWPOWER_EN
        // Standby: no access, data_out holds
        doRead (14'h0100, 16'hA5C3, "lp_pre");
        applyStimulus(14'h0200, 16'hFFFF, 4'hF, 1'b1, 1'b1, MD_SB, 1'b0, 16'h0, 1'b1, 16'hA5C3, "standby_hold");
        doRead (14'h0200, 16'h1B3D, "standby_kept");

        // Sleep forces zero at once, register stays cleared afterwards
        doRead (14'h0100, 16'hA5C3, "pre_sleep");
        doIdle();
        applyStimulus(14'h0100, 16'h0, 4'h0, 1'b0, 1'b0, MD_SL,  1'b1, 16'h0, 1'b1, 16'h0, "sleep_force");
        applyStimulus(14'h0100, 16'h0, 4'h0, 1'b0, 1'b0, MD_RUN, 1'b1, 16'h0, 1'b1, 16'h0, "sleep_cleared");
        doRead (14'h0100, 16'hA5C3, "sleep_kept");

        // Power-off for two cycles: contents lost, no write
        doIdle();
        applyStimulus(14'h0300, 16'h7777, 4'hF, 1'b1, 1'b1, MD_PO, 1'b1, 16'h0, 1'b1, 16'h0, "poff_1");
        applyStimulus(14'h0300, 16'h7777, 4'hF, 1'b1, 1'b1, MD_PO, 1'b0, 16'h0, 1'b1, 16'h0, "poff_2");
        doRead (14'h0100, 16'h0000, "poff_lost");
        doRead (14'h0300, 16'h0000, "poff_nowrite");
        doWrite(14'h0200, 16'hABCD, 4'b0001, 1'b1, 16'h0000, "poff_prior");
        doRead (14'h0200, 16'h000D, "poff_partial");
`else
        // Low-power pins ignored in this build
        doWrite(14'h0400, 16'h1111, 4'hF, 1'b0, 16'h0, "wr_0400");
        applyStimulus(14'h0400, 16'h5A5A, 4'hF, 1'b1, 1'b1, MD_SLPO, 1'b0, 16'h0, 1'b1, 16'h1111, "nolp_wr_prior");
        applyStimulus(14'h0400, 16'h0000, 4'h0, 1'b0, 1'b1, MD_SLPO, 1'b0, 16'h0, 1'b1, 16'h5A5A, "nolp_rd");
        applyStimulus(14'h0100, 16'h0000, 4'h0, 1'b0, 1'b1, MD_SB,   1'b0, 16'h0, 1'b1, 16'hA5C3, "nolp_standby");
        doRead (14'h0400, 16'h5A5A, "nolp_kept");
`endif

        doIdle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (due_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: pending=%0d required=0", due_q.size());
        end
        printSummary();
        $finish;
    end

endmodule
